// File: rtl/se030_pkg.sv
// se030_pkg -- shared types and defaults for the slow-bus I/O bridge.
//   bus_state_t : slow-bus cycle FSM states
//   req_t       : fast-bus request fields captured at cycle start
//   *_DEF       : default parameter values for iobus_bridge
//   LN_*        : lane index of each Mac input in the synchroniser array
package se030_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S0,
    S2,
    ACK_WAIT,
    S_END,
    DONE
  } bus_state_t;

  typedef struct packed {
    logic rnw;
    logic uds_n;
    logic lds_n;
  } req_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 64;
  localparam int TO_W_DEF        = 7;

  // Mac inputs are synchronised as one lane array.
  localparam int NUM_MAC_IN = 4;
  localparam int LN_C8M     = 0;
  localparam int LN_DTACK   = 1;
  localparam int LN_VPA     = 2;
  localparam int LN_BERR    = 3;

  // Reset level per lane: acks are active-low, so they idle high.
  localparam logic [NUM_MAC_IN-1:0] MAC_IN_RST = 4'b1110;

endpackage

// File: rtl/mac_sync.sv
// mac_sync -- STAGES-deep synchroniser for one asynchronous Mac input,
// plus one-FCLK pulses on the synchronised rising and falling edges.
//   FCLK, Reset : fast clock, async active-high reset
//   d           : raw asynchronous input
//   q           : synchronised level
//   rise, fall  : single-cycle edge pulses of q
module mac_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // [STAGES-1:0] is the synchroniser chain; the top bit holds last cycle's q.
  logic [STAGES:0] sync_pipe;

  always_ff @(posedge FCLK or posedge Reset) begin
    if (Reset) sync_pipe <= {(STAGES+1){RST_VAL}};
    else       sync_pipe <= {sync_pipe[STAGES-1:0], d};
  end

  assign q    = sync_pipe[STAGES-1];
  assign rise =  sync_pipe[STAGES-1] & ~sync_pipe[STAGES];
  assign fall = ~sync_pipe[STAGES-1] &  sync_pipe[STAGES];

endmodule

// File: rtl/iobus_bridge.sv
// iobus_bridge -- runs a 68000-style slow-bus cycle (S0..S7) paced by C8M
// for a fast-bus I/O access, then reports completion to the fast side.
//   FCLK, Reset            : fast clock, async active-high reset
//   ASActive, ASInactive   : fast strobe asserted / fully released
//   IOCS, RnW, nUDS, nLDS  : fast-bus access decode, direction, data strobes
//   C8M, nDTACKMac,
//   nVPAMac, nBERRMacIn    : raw slow-bus clock and acknowledges (async)
//   nASMac, nUDSMac,
//   nLDSMac, RnWMac        : slow-bus strobes and direction
//   nDoutOE                : low drives write data onto the slow bus
//   Ready, nBERRMac        : cycle done / bus error, held until ASInactive
//   IOBusy                 : FSM outside IDLE
module iobus_bridge
  import se030_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic IOCS,
  input  logic RnW,
  input  logic nUDS,
  input  logic nLDS,
  input  logic C8M,
  input  logic nDTACKMac,
  input  logic nVPAMac,
  input  logic nBERRMacIn,
  output logic nASMac,
  output logic nUDSMac,
  output logic nLDSMac,
  output logic RnWMac,
  output logic nDoutOE,
  output logic Ready,
  output logic nBERRMac,
  output logic IOBusy
);

  logic [NUM_MAC_IN-1:0] mac_raw, mac_s, mac_r, mac_f;

  assign mac_raw = {nBERRMacIn, nVPAMac, nDTACKMac, C8M};

  for (genvar g = 0; g < NUM_MAC_IN; g++) begin : g_sync
    mac_sync #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(MAC_IN_RST[g])
    ) u_sync (
      .FCLK (FCLK),
      .Reset(Reset),
      .d    (mac_raw[g]),
      .q    (mac_s[g]),
      .rise (mac_r[g]),
      .fall (mac_f[g])
    );
  end

  // Only C8M edges and ack levels are consumed.
  logic unused_sync;
  assign unused_sync = ^{mac_s[LN_C8M], mac_r[NUM_MAC_IN-1:1], mac_f[NUM_MAC_IN-1:1]};

  logic c8m_r, c8m_f, dtack_s, vpa_s, berr_s;
  assign c8m_r   = mac_r[LN_C8M];
  assign c8m_f   = mac_f[LN_C8M];
  assign dtack_s = mac_s[LN_DTACK];
  assign vpa_s   = mac_s[LN_VPA];
  assign berr_s  = mac_s[LN_BERR];

  bus_state_t      state;
  req_t            req;
  logic [TO_W-1:0] to_cnt;
  logic            berr_f;  // cycle ends in bus error
  logic            abort;   // CPU released the strobe mid-cycle

  always_ff @(posedge FCLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      req      <= '{rnw: 1'b1, uds_n: 1'b1, lds_n: 1'b1};
      to_cnt   <= '0;
      berr_f   <= 1'b0;
      abort    <= 1'b0;
      nASMac   <= 1'b1;
      nUDSMac  <= 1'b1;
      nLDSMac  <= 1'b1;
      RnWMac   <= 1'b1;
      nDoutOE  <= 1'b1;
      Ready    <= 1'b0;
      nBERRMac <= 1'b1;
      IOBusy   <= 1'b0;
    end else begin
      // An abort is remembered; the Mac cycle itself is never cut short.
      if ((state inside {S0, S2, ACK_WAIT, S_END}) && ASInactive) abort <= 1'b1;

      case (state)
        IDLE: begin
          if (ASActive && IOCS && !Ready) begin
            state  <= S0;
            req    <= '{rnw: RnW, uds_n: nUDS, lds_n: nLDS};
            RnWMac <= RnW;
            IOBusy <= 1'b1;
            abort  <= 1'b0;
            berr_f <= 1'b0;
          end
        end

        // Wait for a fresh C8M rise so the cycle starts phase-aligned.
        S0: begin
          if (c8m_r) begin
            state  <= S2;
            nASMac <= 1'b0;
            if (req.rnw) begin
              nUDSMac <= req.uds_n;
              nLDSMac <= req.lds_n;
            end else begin
              nDoutOE <= 1'b0;
            end
          end
        end

        // Write data strobes follow AS by half a C8M period.
        S2: begin
          if (c8m_f) begin
            state <= ACK_WAIT;
            if (!req.rnw) begin
              nUDSMac <= req.uds_n;
              nLDSMac <= req.lds_n;
            end
          end
        end

        ACK_WAIT: begin
          if (c8m_f) begin
            if (!berr_s) begin
              state  <= S_END;
              berr_f <= 1'b1;
              to_cnt <= '0;
            end else if (!dtack_s || !vpa_s) begin
              state  <= S_END;
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
              state  <= S_END;
              berr_f <= 1'b1;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        S_END: begin
          if (c8m_f) begin
            nASMac  <= 1'b1;
            nUDSMac <= 1'b1;
            nLDSMac <= 1'b1;
            nDoutOE <= 1'b1;
            if (abort || ASInactive) begin
              state  <= IDLE;
              RnWMac <= 1'b1;
              IOBusy <= 1'b0;
            end else begin
              state <= DONE;
              if (berr_f) nBERRMac <= 1'b0;
              else        Ready    <= 1'b1;
            end
          end
        end

        DONE: begin
          if (ASInactive) begin
            state    <= IDLE;
            Ready    <= 1'b0;
            nBERRMac <= 1'b1;
            RnWMac   <= 1'b1;
            IOBusy   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_bridge.sv
// tb_iobus_bridge -- randomized bench for iobus_bridge. A slow-bus responder
// acknowledges after a chosen number of C8M falls; expected responses are
// queued at issue time and checked by an independent monitor.
module tb_iobus_bridge;

  localparam int TO = 64;

  logic FCLK = 1'b0;
  logic C8M  = 1'b0;
  logic Reset, ASActive, ASInactive, IOCS, RnW, nUDS, nLDS;
  logic nDTACKMac, nVPAMac, nBERRMacIn;
  logic nASMac, nUDSMac, nLDSMac, RnWMac, nDoutOE, Ready, nBERRMac, IOBusy;

  iobus_bridge #(.SYNC_STAGES(2), .TIMEOUT(TO), .TO_W(7)) dut (
    .FCLK      (FCLK),
    .Reset     (Reset),
    .ASActive  (ASActive),
    .ASInactive(ASInactive),
    .IOCS      (IOCS),
    .RnW       (RnW),
    .nUDS      (nUDS),
    .nLDS      (nLDS),
    .C8M       (C8M),
    .nDTACKMac (nDTACKMac),
    .nVPAMac   (nVPAMac),
    .nBERRMacIn(nBERRMacIn),
    .nASMac    (nASMac),
    .nUDSMac   (nUDSMac),
    .nLDSMac   (nLDSMac),
    .RnWMac    (RnWMac),
    .nDoutOE   (nDoutOE),
    .Ready     (Ready),
    .nBERRMac  (nBERRMac),
    .IOBusy    (IOBusy)
  );

  always #5ns FCLK = ~FCLK;
  initial begin
    #3ns;
    forever #41.3ns C8M = ~C8M;
  end

  wire [7:0] outvec = {nASMac, nUDSMac, nLDSMac, RnWMac, nDoutOE, Ready, nBERRMac, IOBusy};

  typedef struct {
    bit berr;
    bit rnw;
    bit uds;
    bit lds;
    int falls;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   excl_bad = 0;

  // ack kinds: 0 DTACK, 1 VPA, 2 BERR, 3 BERR+DTACK, 4 none
  int ack_type = 4, ack_k = 1;

  // monitor / recorder state
  bit c8m_prev = 1'b0, as_prev = 1'b1, rdy_prev = 1'b0, nberr_prev = 1'b1;
  int win_falls = 0, last_falls = 0;
  bit rnw_at_as, uds_at_as, lds_at_as, seen_uds, seen_lds, seen_doe;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  always @(negedge FCLK) begin : mon
    exp_t e;
    bit c8m_fall, c8m_rise;
    c8m_fall = c8m_prev && !C8M;
    c8m_rise = !c8m_prev && C8M;
    c8m_prev = C8M;

    // record what the slow bus saw during the AS-low window
    if (!nASMac && as_prev) begin
      win_falls = 0;
      rnw_at_as = RnWMac;
      uds_at_as = !nUDSMac;
      lds_at_as = !nLDSMac;
      seen_uds  = 1'b0;
      seen_lds  = 1'b0;
      seen_doe  = 1'b0;
    end
    if (!nASMac) begin
      if (c8m_fall) win_falls++;
      seen_uds |= !nUDSMac;
      seen_lds |= !nLDSMac;
      seen_doe |= !nDoutOE;
    end
    if (nASMac && !as_prev) last_falls = win_falls;
    as_prev = nASMac;

    // slow-bus responder: ack goes out on the C8M rise after fall ack_k
    if (!nASMac && c8m_rise && win_falls == ack_k) begin
      case (ack_type)
        0: nDTACKMac = 1'b0;
        1: nVPAMac = 1'b0;
        2: nBERRMacIn = 1'b0;
        3: begin nBERRMacIn = 1'b0; nDTACKMac = 1'b0; end
        default: ;
      endcase
    end
    if (nASMac) begin
      nDTACKMac  = 1'b1;
      nVPAMac    = 1'b1;
      nBERRMacIn = 1'b1;
    end

    if (Ready && !nBERRMac) excl_bad++;

    if ((Ready && !rdy_prev) || (!nBERRMac && nberr_prev)) begin
      if (exp_q.size() == 0) fail_now("unexpected_response");
      else begin
        e = exp_q.pop_front();
        chk("resp_berr", !nBERRMac, e.berr);
        chk("resp_ready", Ready, !e.berr);
        chk("as_falls", last_falls, e.falls);
        chk("rnw_mac", rnw_at_as, e.rnw);
        chk("ds_at_as", {uds_at_as, lds_at_as}, e.rnw ? {e.uds, e.lds} : 2'b00);
        chk("uds_seen", seen_uds, e.uds);
        chk("lds_seen", seen_lds, e.lds);
        chk("doe_seen", seen_doe, !e.rnw);
      end
    end
    rdy_prev   = Ready;
    nberr_prev = nBERRMac;
  end

  task automatic do_txn(input bit rnw, input bit uds, input bit lds,
                        input int kind, input int k, input bit abort);
    exp_t e;
    int   falls_exp;
    falls_exp = (kind == 4) ? TO + 2 : k + 2;
    ack_type  = kind;
    ack_k     = k;
    if (!abort) begin
      e.berr  = (kind >= 2);
      e.rnw   = rnw;
      e.uds   = uds;
      e.lds   = lds;
      e.falls = falls_exp;
      exp_q.push_back(e);
    end
    @(negedge FCLK);
    RnW = rnw; nUDS = !uds; nLDS = !lds;
    IOCS = 1'b1; ASActive = 1'b1; ASInactive = 1'b0;
    if (abort) begin
      for (int i = 0; i < 200 && nASMac; i++) @(negedge FCLK);
      if (nASMac) fail_now("abort_as_start");
      @(negedge FCLK);
      ASActive = 1'b0; IOCS = 1'b0; ASInactive = 1'b1;
      @(negedge FCLK);
      ASInactive = 1'b0;
      for (int i = 0; i < 2000 && IOBusy; i++) @(negedge FCLK);
      @(negedge FCLK);
      chk("abort_end", {Ready, nBERRMac, IOBusy, RnWMac}, 4'b0101);
      chk("abort_falls", last_falls, falls_exp);
      ASInactive = 1'b1;
    end else begin
      for (int i = 0; i < 2000 && !Ready && nBERRMac; i++) @(negedge FCLK);
      if (!Ready && nBERRMac) begin
        fail_now("resp_timeout");
        exp_q.delete();
      end else begin
        repeat ($urandom_range(1, 6)) @(negedge FCLK);
        chk("hold", {Ready, nBERRMac}, (kind >= 2) ? 2'b00 : 2'b11);
      end
      ASActive = 1'b0; IOCS = 1'b0; ASInactive = 1'b1;
      repeat (2) @(negedge FCLK);
      chk("release", {Ready, nBERRMac, IOBusy, RnWMac}, 4'b0101);
    end
    repeat ($urandom_range(1, 10)) @(negedge FCLK);
  endtask

  initial begin
    Reset = 1'b1; ASActive = 1'b0; ASInactive = 1'b1; IOCS = 1'b0;
    RnW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    nDTACKMac = 1'b1; nVPAMac = 1'b1; nBERRMacIn = 1'b1;
    repeat (3) @(negedge FCLK);
    chk("reset_state", outvec, 8'b11111010);
    Reset = 1'b0;
    repeat (20) @(negedge FCLK);

    do_txn(1, 1, 1, 0, 3, 0);   // read, DTACK 3 C8M in
    do_txn(0, 1, 0, 0, 2, 0);   // write upper byte only
    do_txn(1, 1, 1, 3, 2, 0);   // BERR together with DTACK
    do_txn(0, 0, 1, 4, 1, 0);   // no ack -> timeout
    do_txn(1, 1, 1, 0, 2, 1);   // strobe released during S2

    // async reset while waiting for an ack
    ack_type = 4; ack_k = 1;
    @(negedge FCLK);
    RnW = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    IOCS = 1'b1; ASActive = 1'b1; ASInactive = 1'b0;
    for (int i = 0; i < 200 && nASMac; i++) @(negedge FCLK);
    repeat (20) @(negedge FCLK);
    chk("pre_reset_busy", {nASMac, nDoutOE, IOBusy}, 3'b001);
    #2ns Reset = 1'b1;
    #1ns chk("reset_async", outvec, 8'b11111010);
    ASActive = 1'b0; IOCS = 1'b0; ASInactive = 1'b1;
    repeat (3) @(negedge FCLK);
    Reset = 1'b0;
    repeat (5) @(negedge FCLK);
    do_txn(1, 0, 1, 1, 1, 0);   // normal cycle after reset

    for (int t = 0; t < 30; t++) begin
      int r, kr, kind;
      bit rnw, ab;
      rnw = 1'($urandom_range(0, 1));
      r   = $urandom_range(1, 3);
      kr  = $urandom_range(0, 9);
      case (kr)
        4, 5:    kind = 1;
        6:       kind = 2;
        7:       kind = 3;
        8:       kind = 4;
        default: kind = 0;
      endcase
      ab = ($urandom_range(0, 5) == 0);
      do_txn(rnw, r[1], r[0], kind, $urandom_range(1, 5), ab);
    end

    chk("exclusive", excl_bad, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
